// File: rtl/mem_burst_master.sv
// Burst initiator for the data-memory port: takes one request, issues one beat per cycle,
// closes multi-word bursts with a flush beat, and returns read words as a registered stream.
module mem_burst_master #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    // Request handshake: a request transfers on a rising edge where req_valid=1 and req_ready=1.
    // req_ready is high only while idle; requests offered at other times are dropped, not queued.
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_rw,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [1:0]            req_size,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  done,
    output logic                  proto_err,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_data_in,
    output logic [1:0]            mem_access_size,
    output logic                  mem_rw,
    output logic                  mem_enable,
    input  logic                  mem_busy,
    input  logic [DATA_WIDTH-1:0] mem_data_out,
    output logic [2:0]            dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_FLUSH,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                  r_state;
    logic                    r_rw;
    logic [ADDR_WIDTH-1:0]   r_base;
    logic [1:0]              r_size;
    logic [3:0]              r_k;
    logic [ADDR_WIDTH-1:0]   r_mem_address;
    logic [DATA_WIDTH-1:0]   r_mem_data_in;
    logic [1:0]              r_mem_access_size;
    logic                    r_mem_rw;
    logic                    r_mem_enable;
    logic [DATA_WIDTH-1:0]   r_rd_data;
    logic                    r_rd_valid;
    logic                    r_done;
    logic                    r_proto_err;
    // Two-stage trackers: read beats awaiting data, and burst beats awaiting the busy check
    logic                    r_rd_p0;
    logic                    r_rd_p1;
    logic                    r_chk0;
    logic                    r_chk1;

    logic [ADDR_WIDTH-1:0]   w_beat_addr;
    logic [3:0]              w_last_k;
    logic                    w_last;
    logic                    w_burst;

    always_comb begin
        w_last_k = 4'd0;
        case (r_size)
            2'b00:   w_last_k = 4'd0;
            2'b01:   w_last_k = 4'd3;
            2'b10:   w_last_k = 4'd7;
            default: w_last_k = 4'd15;
        endcase
    end

    assign w_beat_addr = r_base + {{(ADDR_WIDTH-6){1'b0}}, r_k, 2'b00};
    assign w_last      = (r_k == w_last_k);
    assign w_burst     = (r_size != 2'b00);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state           <= S_IDLE;
            r_rw              <= 1'b0;
            r_base            <= '0;
            r_size            <= 2'b00;
            r_k               <= 4'd0;
            r_mem_address     <= '0;
            r_mem_data_in     <= '0;
            r_mem_access_size <= 2'b00;
            r_mem_rw          <= 1'b0;
            r_mem_enable      <= 1'b0;
            r_rd_data         <= '0;
            r_rd_valid        <= 1'b0;
            r_done            <= 1'b0;
            r_proto_err       <= 1'b0;
            r_rd_p0           <= 1'b0;
            r_rd_p1           <= 1'b0;
            r_chk0            <= 1'b0;
            r_chk1            <= 1'b0;
        end else begin
            r_done     <= 1'b0;
            r_rd_valid <= 1'b0;
            r_rd_p0    <= 1'b0;
            r_chk0     <= 1'b0;
            r_rd_p1    <= r_rd_p0;
            r_chk1     <= r_chk0;
            if (r_rd_p1) begin
                r_rd_valid <= 1'b1;
                r_rd_data  <= mem_data_out;
            end
            // Busy is checked one edge after the responder sampled a non-final burst beat
            if (r_chk1 && !mem_busy) begin
                r_proto_err <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    r_mem_enable <= 1'b0;
                    if (req_valid) begin
                        r_rw    <= req_rw;
                        r_base  <= req_addr & ~ADDR_WIDTH'(3);
                        r_size  <= req_size;
                        r_k     <= 4'd0;
                        r_state <= req_rw ? S_READ : S_WRITE;
                    end
                end
                S_WRITE, S_READ: begin
                    r_mem_enable      <= 1'b1;
                    r_mem_rw          <= r_rw;
                    r_mem_address     <= w_beat_addr;
                    r_mem_access_size <= r_size;
                    if (r_rw) begin
                        r_rd_p0 <= 1'b1;
                    end else begin
                        r_mem_data_in <= wr_data;
                    end
                    r_chk0 <= w_burst && !w_last;
                    if (w_last) begin
                        if (w_burst) begin
                            r_state <= S_FLUSH;
                        end else begin
                            r_state <= r_rw ? S_DRAIN : S_DONE;
                        end
                    end else begin
                        r_k <= r_k + 4'd1;
                    end
                end
                S_FLUSH: begin
                    // Address, size and rw hold their last-beat values for the flush beat
                    r_mem_enable <= 1'b1;
                    r_state      <= r_rw ? S_DRAIN : S_DONE;
                end
                S_DRAIN: begin
                    r_mem_enable <= 1'b0;
                    if (!r_rd_p0) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_mem_enable <= 1'b0;
                    r_done       <= 1'b1;
                    r_state      <= S_IDLE;
                end
                default: begin
                    r_mem_enable <= 1'b0;
                    r_state      <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready       = (r_state == S_IDLE);
    assign wr_ready        = (r_state == S_WRITE);
    assign rd_data         = r_rd_data;
    assign rd_valid        = r_rd_valid;
    assign done            = r_done;
    assign proto_err       = r_proto_err;
    assign mem_address     = r_mem_address;
    assign mem_data_in     = r_mem_data_in;
    assign mem_access_size = r_mem_access_size;
    assign mem_rw          = r_mem_rw;
    assign mem_enable      = r_mem_enable;
    assign dbg_state       = r_state;

endmodule

// File: tb/tb_mem_burst_master.sv
// Bench for mem_burst_master: burst memory responder, transaction monitor and a
// word-level reference model that derives beats, read data and timing from the request.
module tb_mem_burst_master;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_rw = 1'b0;
    logic [31:0] req_addr = '0;
    logic [1:0]  req_size = 2'b00;
    logic [31:0] wr_data = '0;
    logic        wr_ready;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        done;
    logic        proto_err;
    logic [31:0] mem_address;
    logic [31:0] mem_data_in;
    logic [1:0]  mem_access_size;
    logic        mem_rw;
    logic        mem_enable;
    logic        mem_busy = 1'b0;
    logic [31:0] mem_data_out = '0;
    logic [2:0]  dbg_state;

    always #5 clock = ~clock;

    mem_burst_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
        .req_addr(req_addr), .req_size(req_size),
        .wr_data(wr_data), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_valid(rd_valid), .done(done), .proto_err(proto_err),
        .mem_address(mem_address), .mem_data_in(mem_data_in),
        .mem_access_size(mem_access_size), .mem_rw(mem_rw), .mem_enable(mem_enable),
        .mem_busy(mem_busy), .mem_data_out(mem_data_out), .dbg_state(dbg_state)
    );

    int n_checks = 0;
    int n_pass   = 0;

    function automatic int size_n(input logic [1:0] s);
        case (s)
            2'b00:   return 1;
            2'b01:   return 4;
            2'b10:   return 8;
            default: return 16;
        endcase
    endfunction

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return a ^ 32'h5A5A_1234;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    // Monitor: records each beat the memory samples, each read word and each done pulse
    int          cyc = 0;
    logic [31:0] mon_addr [2048];
    logic [31:0] mon_data [2048];
    logic        mon_rw   [2048];
    logic [1:0]  mon_sz   [2048];
    int          mon_t    [2048];
    int          beat_n = 0;
    logic [31:0] rd_q     [2048];
    int          rd_t     [2048];
    int          rd_n = 0;
    int          done_t   [256];
    int          done_n = 0;

    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (mem_enable && beat_n < 2048) begin
            mon_addr[beat_n] <= mem_address;
            mon_data[beat_n] <= mem_data_in;
            mon_rw[beat_n]   <= mem_rw;
            mon_sz[beat_n]   <= mem_access_size;
            mon_t[beat_n]    <= cyc;
            beat_n           <= beat_n + 1;
        end
        if (rd_valid && rd_n < 2048) begin
            rd_q[rd_n] <= rd_data;
            rd_t[rd_n] <= cyc;
            rd_n       <= rd_n + 1;
        end
        if (done && done_n < 256) begin
            done_t[done_n] <= cyc;
            done_n         <= done_n + 1;
        end
    end

    // Responder: 4 KiB window, beat counter rearmed by the flush beat, busy held through a burst
    logic [31:0] resp_mem [1024];
    bit          resp_vld [1024];
    int          bcnt = 0;
    bit          drop_en = 1'b0;

    always @(posedge clock) begin
        if (reset) begin
            bcnt     <= 0;
            mem_busy <= 1'b0;
        end else if (mem_enable) begin
            if (mem_access_size != 2'b00 && bcnt == size_n(mem_access_size)) begin
                bcnt     <= 0;
                mem_busy <= 1'b0;
            end else begin
                if (!mem_rw) begin
                    resp_mem[mem_address[11:2]] <= mem_data_in;
                    resp_vld[mem_address[11:2]] <= 1'b1;
                end else begin
                    mem_data_out <= resp_vld[mem_address[11:2]] ? resp_mem[mem_address[11:2]]
                                                                : dflt(mem_address);
                end
                if (mem_access_size != 2'b00) bcnt <= bcnt + 1;
                mem_busy <= (mem_access_size != 2'b00) && (bcnt + 1 < size_n(mem_access_size))
                            && !(drop_en && bcnt == 1);
            end
        end
    end

    // Reference model of memory contents as seen through completed write requests
    logic [31:0] model_mem [1024];
    bit          model_vld [1024];
    logic [31:0] wdata [16];
    bit          perr_exp = 1'b0;

    task automatic run_req(input bit rw, input logic [31:0] addr, input logic [1:0] sz,
                           input bit spurious, input bit drop);
        int n, a, b0, r0, d0, wi, t, exp_beats, last_reg, done_exp, kk;
        logic [31:0] base, wa;
        n = size_n(sz);
        base = addr & 32'hFFFF_FFFC;
        drop_en = drop;
        if (drop) perr_exp = 1'b1;
        t = 0;
        while (!req_ready && t < 100) begin
            @(negedge clock);
            t++;
        end
        check("req_ready_wait", req_ready, 1);
        b0 = beat_n; r0 = rd_n; d0 = done_n;
        req_valid = 1'b1; req_rw = rw; req_addr = addr; req_size = sz;
        a = cyc;
        @(negedge clock);
        req_valid = 1'b0;
        wi = 0; t = 0;
        while (done_n == d0 && t < 80) begin
            if (wr_ready && wi < n) begin
                wr_data = wdata[wi];
                wi++;
            end
            if (t == 1) check("busy_not_ready", req_ready, 0);
            req_valid = spurious && (t == 2);
            if (spurious && t == 2) req_addr = 32'h8002_0F00;
            @(negedge clock);
            t++;
        end
        req_valid = 1'b0;
        check("done_seen", done_n != d0, 1);
        repeat (3) @(negedge clock);
        check("done_pulses", done_n - d0, 1);
        exp_beats = n + ((n > 1) ? 1 : 0);
        last_reg  = a + exp_beats;
        done_exp  = (rw ? (a + n + 3) : (last_reg + 1)) + 1;
        check("done_time", done_t[d0], done_exp);
        check("beat_count", beat_n - b0, exp_beats);
        for (int k = 0; k < exp_beats && k < beat_n - b0; k++) begin
            kk = (k < n) ? k : n - 1;
            check("beat_addr", mon_addr[b0+k], base + 32'(4 * kk));
            check("beat_ctl", {mon_rw[b0+k], mon_sz[b0+k]}, {rw, sz});
            check("beat_time", mon_t[b0+k], a + 2 + k);
            if (!rw && k < n) check("beat_wdata", mon_data[b0+k], wdata[k]);
        end
        if (rw) begin
            check("rd_count", rd_n - r0, n);
            for (int k = 0; k < n && k < rd_n - r0; k++) begin
                wa = base + 32'(4 * k);
                check("rd_word", rd_q[r0+k], model_vld[wa[11:2]] ? model_mem[wa[11:2]] : dflt(wa));
                check("rd_time", rd_t[r0+k], a + 4 + k);
            end
        end else begin
            check("wr_no_rd", rd_n - r0, 0);
            for (int k = 0; k < n; k++) begin
                wa = base + 32'(4 * k);
                model_mem[wa[11:2]] = wdata[k];
                model_vld[wa[11:2]] = 1'b1;
            end
        end
        check("proto_err", proto_err, perr_exp);
        drop_en = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a, r0, d0, t;
        logic [1:0] sz;
        bit rw;
        reset = 1'b1;
        repeat (3) @(negedge clock);
        check("reset_ready", req_ready, 1);
        check("reset_ctl", {wr_ready, rd_valid, done, proto_err, mem_enable, mem_rw, mem_access_size}, 0);
        check("reset_addr", mem_address, 0);
        check("reset_data", {mem_data_in, rd_data}, 0);
        reset = 1'b0;
        @(negedge clock);

        // Single-word write
        wdata[0] = 32'hDEADBEEF;
        run_req(1'b0, 32'h8002_0000, 2'b00, 1'b0, 1'b0);
        check("mem_word0", resp_mem[0], 32'hDEADBEEF);

        // Four-word write with flush
        wdata[0] = 32'h11111111; wdata[1] = 32'h22222222;
        wdata[2] = 32'h33333333; wdata[3] = 32'h44444444;
        run_req(1'b0, 32'h8002_0010, 2'b01, 1'b0, 1'b0);

        // Preload eight words, then read them back
        for (int i = 0; i < 8; i++) wdata[i] = $urandom();
        run_req(1'b0, 32'h8002_0000, 2'b10, 1'b0, 1'b0);
        run_req(1'b1, 32'h8002_0000, 2'b10, 1'b0, 1'b0);

        // Back-to-back 16-word write then read, with a request offered mid-burst
        for (int i = 0; i < 16; i++) wdata[i] = $urandom();
        run_req(1'b0, 32'h8002_0040, 2'b11, 1'b1, 1'b0);
        run_req(1'b1, 32'h8002_0040, 2'b11, 1'b1, 1'b0);

        // Responder drops busy after beat 1; error is sticky across the next request
        run_req(1'b1, 32'h8002_0010, 2'b01, 1'b0, 1'b1);
        wdata[0] = $urandom();
        run_req(1'b0, 32'h8002_0100, 2'b00, 1'b0, 1'b0);

        // Reset during the third beat of an eight-word read
        t = 0;
        while (!req_ready && t < 100) begin
            @(negedge clock);
            t++;
        end
        req_valid = 1'b1; req_rw = 1'b1; req_addr = 32'h8002_0000; req_size = 2'b10;
        a = cyc;
        @(negedge clock);
        req_valid = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_third_beat", {mem_enable, mem_address}, {1'b1, 32'h8002_0008});
        reset = 1'b1;
        @(negedge clock);
        check("rst_outputs", {mem_enable, done, rd_valid, req_ready}, 4'b0001);
        check("rst_proto_err", proto_err, 0);
        reset = 1'b0;
        perr_exp = 1'b0;
        r0 = rd_n; d0 = done_n;
        repeat (10) @(negedge clock);
        check("rst_no_rd", rd_n - r0, 0);
        check("rst_no_done", done_n - d0, 0);
        run_req(1'b1, 32'h8002_0004, 2'b00, 1'b0, 1'b0);

        // Randomised requests against the model, including unaligned base addresses
        for (int it = 0; it < 14; it++) begin
            rw = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 3));
            for (int i = 0; i < 16; i++) wdata[i] = $urandom();
            run_req(rw, 32'h8002_0000 + 32'($urandom_range(0, 190) * 4) + 32'($urandom_range(0, 3)),
                    sz, (sz != 2'b00) && ($urandom_range(0, 1) == 1), 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
